i2c_target: RTL and testbench
=============================

# i2c_target

Synchronous I2C target (responder) that answers the team's I2C initiator on the same two-wire bus. It oversamples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit address and ACKs it. Write bytes are delivered to a byte-wide user port; read bytes are pulled from the user on request. It drives SDA only as an open-drain pull-down enable and never drives SCL (no clock stretching).

## Interface
- `ADDR`, 7'h50: target address matched against the first byte after START.
- `clk` in 1: system clock. Must be ≥16× SCL frequency.
- `rst` in 1: reset, synchronous, active-high.
- `scl_in` in 1: bus SCL level (asynchronous to `clk`).
- `sda_in` in 1: bus SDA level (asynchronous to `clk`).
- `sda_oe` out 1: 1 = pull SDA low, 0 = release. Reset 0.
- `rx_data` out 8: last byte written by the initiator. Reset 8'h00.
- `rx_valid` out 1: one-`clk` pulse when `rx_data` updates. Reset 0.
- `tx_data` in 8: byte to return on a read. Sampled on the cycle after `tx_req`.
- `tx_req` out 1: one-`clk` pulse requesting the next read byte. Reset 0.
- `busy` out 1: high from address match until STOP, or until the next START. Reset 0.

## Operation
- Input path:
  - 2-flop synchronizer on each line, then a third flop for edge detect.
  - A qualified event is therefore seen 3 `clk` after the pin change.
- Bus events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bits are sampled on the detected SCL rise.
  - `sda_oe` changes only on the detected SCL fall.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT.
- IDLE -> ADDR on START. A START in any state -> ADDR and resets the bit counter (repeated start). A STOP in any state -> IDLE with `sda_oe`=0 and `busy`=0.
- ADDR:
  - Shift 8 bits, MSB first: 7 address bits, then R/W.
  - On a match, `sda_oe`=1 on the following SCL fall -> ADDR_ACK.
  - On a mismatch -> WAIT with no ACK.
- ADDR_ACK:
  - On the SCL fall ending the ACK bit, go to WR_BYTE (R/W=0) or RD_BYTE (R/W=1).
  - For a read, `tx_req` pulses on the ACK-bit SCL rise. `tx_data` is loaded into the shift register on the next cycle.
- WR_BYTE: shift 8 bits. On the 8th SCL rise, `rx_data` <= byte and `rx_valid` pulses. The target always ACKs (WR_ACK), then returns to WR_BYTE.
- RD_BYTE:
  - Drive `sda_oe` = ~bit (MSB first) at each SCL fall.
  - After 8 bits, release SDA -> RD_ACK.
- RD_ACK: sample the initiator's bit on SCL rise.
  - 0 (ACK): pulse `tx_req`, load the next byte -> RD_BYTE.
  - 1 (NACK) -> WAIT.
- WAIT: `sda_oe`=0. Leave only on START or STOP.
- Bit counter: 3 bits, wraps 7->0 at each byte boundary.
- Reset mid-transfer: all outputs return to reset values within one `clk`, state IDLE. The following START is handled normally.

## Timing
- SDA ACK pull-down:
  - Asserted 1 `clk` after the detected SCL fall following bit 8, i.e. 4 `clk` after the pin edge.
  - Released at the detected fall after the ACK clock.
- `rx_valid`: 1 `clk` after the detected 8th rise.
- `tx_req` to load: `tx_data` must be valid the cycle after the `tx_req` pulse. The first driven bit appears on the next SCL fall.
- START/STOP vs. SCL edge: if the synchronized SDA and SCL change in the same `clk`, it is an SCL edge, not a START/STOP.

## Structure
- Shared package `i2c_pkg`:
  - state enum (also usable by the initiator),
  - R/W encoding constants (READ=1, WRITE=0),
  - ACK=0 / NACK=1.
- One sub-module, `i2c_sync_edge`: a 2-flop synchronizer plus edge detector, instanced for SCL and SDA. It outputs the level plus `rise`/`fall` pulses.

## Test plan
- Write to 0x50, data 0xA5 then 0x3C, then STOP:
  - ACK on the address and on both bytes.
  - `rx_valid` pulses twice, `rx_data` = 0xA5 then 0x3C.
  - `busy` falls at STOP.
- Address 0x51 with write, data 0xFF: `sda_oe` stays 0 for the entire transfer, no `rx_valid`, state WAIT until STOP.
- Read from 0x50, `tx_data`=0x96 then 0x0F, initiator ACK then NACK:
  - Bus carries 0x96 then 0x0F.
  - `tx_req` pulses twice.
  - SDA is released after the NACK.
- Write 0x50 with data 0x12, then repeated START to read 0x50 with `tx_data`=0xC3: `rx_data`=0x12, then bus carries 0xC3, with no STOP needed between.
- Assert `rst` for 1 `clk` during bit 4 of a data byte:
  - `sda_oe`=0, `busy`=0, state IDLE.
  - The next full write of 0x77 is received correctly.
- STOP issued in the middle of a read byte: SDA is released within 4 `clk` of the SDA rise, state IDLE, no further `tx_req`.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus state encoding, R/W and ACK bit values, field widths.
// Used by the target and intended to be reused by the initiator.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    // R/W bit encoding (LSB of the address byte)
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Acknowledge bit values as seen on SDA
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect flop for one bus line.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous bus level
//   level    : synchronized level, aligned with rise/fall
//   rise     : one-clk pulse on a detected 0->1 transition
//   fall     : one-clk pulse on a detected 1->0 transition
// Flops reset to 1 (idle bus level) so reset never fabricates an edge on an idle bus.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= d;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
            fall  <= ~sync & level;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, byte writes
// delivered to a user port, read bytes pulled from the user. Open-drain SDA only.
// Ports:
//   clk, rst  : system clock (>=16x SCL), synchronous active-high reset
//   scl_in    : bus SCL level (asynchronous)
//   sda_in    : bus SDA level (asynchronous)
//   sda_oe    : 1 = pull SDA low
//   rx_data   : last byte written by the initiator
//   rx_valid  : one-clk pulse when rx_data updates
//   tx_data   : next read byte, sampled the cycle after tx_req
//   tx_req    : one-clk pulse requesting the next read byte
//   busy      : addressed transaction in progress
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR = 7'h50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_req,
    output logic              busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl (
        .clk   (clk),
        .rst   (rst),
        .d     (scl_in),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk   (clk),
        .rst   (rst),
        .d     (sda_in),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // SDA edge with SCL high; a coincident SCL edge wins and is treated as clocking.
    logic start_c, stop_c;
    assign start_c = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
    assign stop_c  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;

    i2c_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [BYTE_W-1:0] shift_in;
    logic              rw_q, rw_d;
    logic              ack_pend_q, ack_pend_d;   // byte/ACK complete, act on next SCL fall
    logic              load_pend_q, load_pend_d; // tx_data is due this cycle
    logic              sda_oe_d;
    logic [BYTE_W-1:0] rx_data_d;
    logic              rx_valid_d, tx_req_d, busy_d;

    assign shift_in = {shreg_q[BYTE_W-2:0], sda_lvl};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            rw_q        <= WRITE;
            ack_pend_q  <= 1'b0;
            load_pend_q <= 1'b0;
            sda_oe      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            rw_q        <= rw_d;
            ack_pend_q  <= ack_pend_d;
            load_pend_q <= load_pend_d;
            sda_oe      <= sda_oe_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            tx_req      <= tx_req_d;
            busy        <= busy_d;
        end
    end

    // Next-state and output logic; START/STOP override every state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        ack_pend_d  = ack_pend_q;
        load_pend_d = 1'b0;
        sda_oe_d    = sda_oe;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        busy_d      = busy;

        if (load_pend_q) begin
            shreg_d = tx_data;
        end

        if (start_c) begin
            state_d    = ST_ADDR;
            cnt_d      = '0;
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else if (stop_c) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d = shift_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            if (shift_in[BYTE_W-1:1] == ADDR) begin
                                rw_d       = shift_in[0];
                                busy_d     = 1'b1;
                                ack_pend_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                    end else if (scl_fall && ack_pend_q) begin
                        ack_pend_d = 1'b0;
                        sda_oe_d   = ~ACK;
                        state_d    = ST_ADDR_ACK;
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_rise && rw_q == READ) begin
                        tx_req_d    = 1'b1;
                        load_pend_d = 1'b1;
                    end else if (scl_fall) begin
                        if (rw_q == WRITE) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_BYTE;
                        end else begin
                            // First read bit goes out on the fall that ends the ACK
                            sda_oe_d = ~shreg_q[BYTE_W-1];
                            shreg_d  = {shreg_q[BYTE_W-2:0], 1'b0};
                            cnt_d    = CNT_W'(1);
                            state_d  = ST_RD_BYTE;
                        end
                    end
                end

                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shreg_d = shift_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            ack_pend_d = 1'b1;
                        end
                    end else if (scl_fall && ack_pend_q) begin
                        ack_pend_d = 1'b0;
                        sda_oe_d   = ~ACK;
                        state_d    = ST_WR_ACK;
                    end
                end

                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_BYTE;
                    end
                end

                ST_RD_BYTE: begin
                    // cnt counts bits already driven; wrap to 0 means all 8 are out
                    if (scl_fall) begin
                        if (cnt_q == '0) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d = ~shreg_q[BYTE_W-1];
                            shreg_d  = {shreg_q[BYTE_W-2:0], 1'b0};
                            cnt_d    = cnt_q + CNT_W'(1);
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == NACK) begin
                            state_d = ST_WAIT;
                        end else begin
                            tx_req_d    = 1'b1;
                            load_pend_d = 1'b1;
                            ack_pend_d  = 1'b1;
                        end
                    end else if (scl_fall && ack_pend_q) begin
                        ack_pend_d = 1'b0;
                        sda_oe_d   = ~shreg_q[BYTE_W-1];
                        shreg_d    = {shreg_q[BYTE_W-2:0], 1'b0};
                        cnt_d      = CNT_W'(1);
                        state_d    = ST_RD_BYTE;
                    end
                end

                ST_WAIT: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus-level initiator model with open-drain SDA.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int TCLK = 10;
    localparam int TQ   = 80;   // SCL low phase; high phase is 2*TQ

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         rx_cnt = 0;
    int         tx_idx = 0;
    logic [7:0] rx_log [0:15];
    logic [7:0] tx_tab [0:7];
    logic       saw_oe = 1'b0;

    // User-side model: log written bytes, serve read bytes, watch the SDA driver
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (rx_cnt < 16) rx_log[rx_cnt] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (tx_req === 1'b1) begin
            tx_data = tx_tab[tx_idx[2:0]];
            tx_idx = tx_idx + 1;
        end
        if (sda_oe === 1'b1) saw_oe = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic bus_bit(input logic b, output logic r);
        #TCLK sda_m = b;
        #(TQ - TCLK) scl = 1'b1;
        #TQ r = sda_line;
        #TQ scl = 1'b0;
    endtask

    task automatic bus_start();
        #TCLK sda_m = 1'b1;
        #TQ scl = 1'b1;
        #TQ sda_m = 1'b0;
        #TQ scl = 1'b0;
    endtask

    task automatic bus_stop();
        #TCLK sda_m = 1'b0;
        #(TQ - TCLK) scl = 1'b1;
        #TQ sda_m = 1'b1;
        #TQ;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_in, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, v[i]);
        bus_bit(ack_in, r);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(1);
        n_chk++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_chk++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
        n_chk++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
        n_chk++; if (tx_req !== 1'b0) $display("FAIL reset_tx_req: got %b want 0", tx_req); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_write();
        logic ack;
        int   base;
        base = rx_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %b want 0", ack); else n_pass++;
        write_byte(8'hA5, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL wr_data0_ack: got %b want 0", ack); else n_pass++;
        write_byte(8'h3C, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL wr_data1_ack: got %b want 0", ack); else n_pass++;
        n_chk++; if (rx_cnt - base !== 2) $display("FAIL wr_rx_count: got %0d want 2", rx_cnt - base); else n_pass++;
        n_chk++; if (rx_log[base] !== 8'hA5) $display("FAIL wr_rx0: got %h want a5", rx_log[base]); else n_pass++;
        n_chk++; if (rx_log[base+1] !== 8'h3C) $display("FAIL wr_rx1: got %h want 3c", rx_log[base+1]); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL wr_busy_before_stop: got %b want 1", busy); else n_pass++;
        bus_stop();
        wait_clk(8);
        n_chk++; if (busy !== 1'b0) $display("FAIL wr_busy_after_stop: got %b want 0", busy); else n_pass++;
        n_chk++; if (dut.state_q !== ST_IDLE) $display("FAIL wr_idle: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
    endtask

    task automatic test_nomatch();
        logic ack;
        int   base;
        base = rx_cnt;
        saw_oe = 1'b0;
        bus_start();
        write_byte(8'hA2, ack);
        n_chk++; if (ack !== 1'b1) $display("FAIL nm_addr_ack: got %b want 1", ack); else n_pass++;
        write_byte(8'hFF, ack);
        n_chk++; if (ack !== 1'b1) $display("FAIL nm_data_ack: got %b want 1", ack); else n_pass++;
        n_chk++; if (dut.state_q !== ST_WAIT) $display("FAIL nm_wait: got %0d want %0d", dut.state_q, ST_WAIT); else n_pass++;
        bus_stop();
        wait_clk(8);
        n_chk++; if (saw_oe !== 1'b0) $display("FAIL nm_sda_oe_seen: got %b want 0", saw_oe); else n_pass++;
        n_chk++; if (rx_cnt !== base) $display("FAIL nm_rx_count: got %0d want %0d", rx_cnt, base); else n_pass++;
        n_chk++; if (dut.state_q !== ST_IDLE) $display("FAIL nm_idle: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] v;
        tx_tab[0] = 8'h96;
        tx_tab[1] = 8'h0F;
        tx_idx = 0;
        bus_start();
        write_byte(8'hA1, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL rd_addr_ack: got %b want 0", ack); else n_pass++;
        read_byte(1'b0, v);
        n_chk++; if (v !== 8'h96) $display("FAIL rd_byte0: got %h want 96", v); else n_pass++;
        read_byte(1'b1, v);
        n_chk++; if (v !== 8'h0F) $display("FAIL rd_byte1: got %h want 0f", v); else n_pass++;
        wait_clk(8);
        n_chk++; if (tx_idx !== 2) $display("FAIL rd_tx_req_count: got %0d want 2", tx_idx); else n_pass++;
        n_chk++; if (sda_oe !== 1'b0) $display("FAIL rd_release_after_nack: got %b want 0", sda_oe); else n_pass++;
        n_chk++; if (dut.state_q !== ST_WAIT) $display("FAIL rd_wait: got %0d want %0d", dut.state_q, ST_WAIT); else n_pass++;
        bus_stop();
        wait_clk(8);
    endtask

    task automatic test_back_to_back();
        logic       ack;
        logic [7:0] v;
        int         base;
        base = rx_cnt;
        tx_tab[0] = 8'hC3;
        tx_idx = 0;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h12, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL rs_wr_ack: got %b want 0", ack); else n_pass++;
        n_chk++; if (rx_log[base] !== 8'h12) $display("FAIL rs_rx: got %h want 12", rx_log[base]); else n_pass++;
        bus_start();
        write_byte(8'hA1, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL rs_rd_addr_ack: got %b want 0", ack); else n_pass++;
        read_byte(1'b1, v);
        n_chk++; if (v !== 8'hC3) $display("FAIL rs_rd_byte: got %h want c3", v); else n_pass++;
        bus_stop();
        wait_clk(8);
    endtask

    task automatic test_reset_mid();
        logic       ack;
        logic       r;
        logic [7:0] b;
        int         base;
        b = 8'h5A;
        bus_start();
        write_byte(8'hA0, ack);
        for (int i = 7; i >= 5; i--) bus_bit(b[i], r);
        #TCLK sda_m = b[4];
        #(TQ - TCLK) scl = 1'b1;
        #(TQ / 2);
        n_chk++; if (busy !== 1'b1) $display("FAIL rm_busy_before: got %b want 1", busy); else n_pass++;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_chk++; if (sda_oe !== 1'b0) $display("FAIL rm_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (dut.state_q !== ST_IDLE) $display("FAIL rm_idle: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
        #(TQ / 2) scl = 1'b0;
        for (int i = 3; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, r);
        bus_stop();
        wait_clk(8);
        base = rx_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL rm_addr_ack: got %b want 0", ack); else n_pass++;
        write_byte(8'h77, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL rm_data_ack: got %b want 0", ack); else n_pass++;
        n_chk++; if (rx_log[base] !== 8'h77) $display("FAIL rm_rx: got %h want 77", rx_log[base]); else n_pass++;
        bus_stop();
        wait_clk(8);
    endtask

    task automatic test_stop_mid_read();
        logic       ack;
        logic       r;
        logic [3:0] nib;
        tx_tab[0] = 8'h0F;
        tx_tab[1] = 8'hAA;
        tx_idx = 0;
        bus_start();
        write_byte(8'hA1, ack);
        for (int i = 3; i >= 0; i--) begin
            bus_bit(1'b1, r);
            nib[i] = r;
        end
        n_chk++; if (nib !== 4'h0) $display("FAIL sm_upper_nibble: got %h want 0", nib); else n_pass++;
        // STOP inside the fifth bit: initiator pulls SDA low while SCL low, then releases with SCL high
        #TCLK sda_m = 1'b0;
        #(TQ - TCLK) scl = 1'b1;
        #TQ sda_m = 1'b1;
        wait_clk(5);
        n_chk++; if (sda_oe !== 1'b0) $display("FAIL sm_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_chk++; if (dut.state_q !== ST_IDLE) $display("FAIL sm_idle: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL sm_busy: got %b want 0", busy); else n_pass++;
        wait_clk(40);
        n_chk++; if (tx_idx !== 1) $display("FAIL sm_tx_req_count: got %0d want 1", tx_idx); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_nomatch();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_stop_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
